mw8080_ram_arbiter: RTL and testbench

- Two-port arbiter that shares one single-port synchronous work/video RAM between two requesters.
- Requester A is the 8080 CPU bus. Requester B is a service port used for hiscore load/save and debug readback.
- CPU has fixed priority. A bounded-wait counter guarantees B cannot starve.
- Sits between the CPU core and the RAM inside the game memory block.

---
 rtl/mw8080_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_mw8080_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw8080_ram_arbiter.sv
// mw8080_ram_arbiter: shares one single-port synchronous work/video RAM
// between the 8080 CPU bus (requester A, fixed priority) and a service
// port (requester B, hiscore load/save and debug readback). A bounded-wait
// counter forces a B slot after MAX_WAIT consecutive A grants that B lost,
// so B cannot starve.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; winner's addr/we/wdata latched on exit
// CYC   | RAM sees addr/we; RAM captures on the closing edge
// RD    | ram_rdata valid; owner's ack raised (and rdata loaded on read)
// ACK   | owner's ack high for exactly this cycle, then back to IDLE
module mw8080_ram_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_sys,
  input  logic          reset,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,

  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,

  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CYC  = 2'd1,
    S_RD   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  // ram_we is cleared after CYC, so the access direction is kept separately
  // for the RD-edge decision on whether to load rdata.
  logic       cur_we;
  logic       any_req;
  logic       b_wins;

  // Winner selection: a starved B overrides the CPU, otherwise CPU first.
  always_comb begin
    any_req = a_req | b_req;
    b_wins  = (b_req && (wait_cnt == WAIT_MAX)) || (b_req && !a_req);
  end

  // Transaction sequencer with registered RAM strobes, acks and read data.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      cur_we    <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            if (b_wins) begin
              ram_addr  <= b_addr;
              ram_we    <= b_we;
              ram_wdata <= b_wdata;
              cur_we    <= b_we;
            end else begin
              ram_addr  <= a_addr;
              ram_we    <= a_we;
              ram_wdata <= a_wdata;
              cur_we    <= a_we;
            end
            owner <= b_wins;
            busy  <= 1'b1;
            state <= S_CYC;
            // Count only grants B actually lost; saturate so B stays forced.
            if (b_wins || !b_req) begin
              wait_cnt <= 4'd0;
            end else if (wait_cnt != WAIT_MAX) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end
        S_CYC: begin
          ram_we <= 1'b0;
          state  <= S_RD;
        end
        S_RD: begin
          state <= S_ACK;
          if (owner) begin
            b_ack <= 1'b1;
            if (!cur_we) begin
              b_rdata <= ram_rdata;
            end
          end else begin
            a_ack <= 1'b1;
            if (!cur_we) begin
              a_rdata <= ram_rdata;
            end
          end
        end
        S_ACK: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mw8080_ram_arbiter.sv
// Bench for mw8080_ram_arbiter: behavioural synchronous RAM, requester
// drivers, and a scoreboard of expected acks (port order, owner, rdata).
module tb_mw8080_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_ack;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ack;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy;
  logic          owner;

  mw8080_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM model with a backdoor preload port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk_sys) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Scoreboard
  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
  } txn_t;

  txn_t          sb[$];
  logic [DW-1:0] sh_mem [0:(1<<AW)-1];
  logic [DW-1:0] sh_last [0:1];
  logic [DW-1:0] mon_a = '0, mon_b = '0;
  txn_t          mon_e;

  task automatic expect_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
    txn_t e;
    e.port = port; e.we = we; e.addr = addr; e.wd = wd;
    if (we) begin
      sh_mem[addr] = wd;
      e.exp_rd = sh_last[port];
    end else begin
      e.exp_rd = sh_mem[addr];
      sh_last[port] = e.exp_rd;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk_sys) begin
    if (ram_we) we_cnt++;
    if (reset) begin
      mon_a = '0;
      mon_b = '0;
    end else if (a_ack || b_ack) begin
      chk("ack_excl", 32'(a_ack & b_ack), 0);
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'(a_ack | b_ack), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_port", 32'(b_ack), 32'(mon_e.port));
        chk("owner", 32'(owner), 32'(mon_e.port));
        chk("busy_ack", 32'(busy), 1);
        if (mon_e.port) begin
          chk("b_rdata", 32'(b_rdata), 32'(mon_e.exp_rd));
          chk("a_rdata_keep", 32'(a_rdata), 32'(mon_a));
          mon_b = mon_e.exp_rd;
        end else begin
          chk("a_rdata", 32'(a_rdata), 32'(mon_e.exp_rd));
          chk("b_rdata_keep", 32'(b_rdata), 32'(mon_b));
          mon_a = mon_e.exp_rd;
        end
      end
    end
  end

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bd_addr = addr; bd_data = data; bd_we = 1'b1;
    sh_mem[addr] = data;
    @(posedge clk_sys); #1;
    bd_we = 1'b0;
  endtask

  // Drive one request, hold until its ack, release on the edge closing ACK.
  task automatic txn(input bit port, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, output int start_c, output int ack_c);
    int  n;
    bit  seen;
    start_c = cyc;
    if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk_sys);
      n++;
      seen = port ? b_ack : a_ack;
    end
    ack_c = cyc;
    chk(port ? "b_ack_seen" : "a_ack_seen", 32'(seen), 1);
    @(posedge clk_sys); #1;
    if (port) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, k0, s1, k1;
    for (int i = 0; i < (1 << AW); i++) sh_mem[i] = '0;
    sh_last[0] = '0;
    sh_last[1] = '0;

    // Reset values
    repeat (3) @(negedge clk_sys);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    chk("rst_b_rdata", 32'(b_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    #2 reset = 1'b0;

    // T1: A read of preloaded location
    preload(13'h0123, 8'h5A);
    expect_txn(0, 0, 13'h0123, 8'h00);
    fork
      txn(0, 0, 13'h0123, 8'h00, s0, k0);
      begin
        repeat (2) @(negedge clk_sys);
        chk("t1_cyc_addr", 32'(ram_addr), 32'h0123);
        chk("t1_cyc_we", 32'(ram_we), 0);
        chk("t1_cyc_busy", 32'(busy), 1);
      end
    join
    chk("t1_latency", 32'(k0 - s0), 3);

    // T2: A write then back-to-back A read of the same location
    we_cnt = 0;
    expect_txn(0, 1, 13'h1FFF, 8'h3C);
    expect_txn(0, 0, 13'h1FFF, 8'h00);
    txn(0, 1, 13'h1FFF, 8'h3C, s0, k0);
    txn(0, 0, 13'h1FFF, 8'h00, s1, k1);
    chk("t2_we_cycles", 32'(we_cnt), 1);
    chk("t2_ack_spacing", 32'(k1 - k0), 4);

    // T3: simultaneous requests, A first then B
    expect_txn(0, 0, 13'h0123, 8'h00);
    expect_txn(1, 0, 13'h1FFF, 8'h00);
    fork
      txn(0, 0, 13'h0123, 8'h00, s0, k0);
      txn(1, 0, 13'h1FFF, 8'h00, s1, k1);
    join
    chk("t3_ack_spacing", 32'(k1 - k0), 4);

    // T4: A streams continuously, B held; B forced in after 4 A grants
    expect_txn(0, 1, 13'h0010, 8'h81);
    expect_txn(0, 1, 13'h0011, 8'h82);
    expect_txn(0, 0, 13'h0123, 8'h00);
    expect_txn(0, 1, 13'h0012, 8'h83);
    expect_txn(1, 0, 13'h0012, 8'h00);
    expect_txn(0, 0, 13'h0010, 8'h00);
    expect_txn(0, 0, 13'h0011, 8'h00);
    fork
      begin
        logic [AW-1:0] aa [6];
        logic [DW-1:0] ad [6];
        bit            aw [6];
        int            as, ak;
        aa = '{13'h0010, 13'h0011, 13'h0123, 13'h0012, 13'h0010, 13'h0011};
        ad = '{8'h81, 8'h82, 8'h00, 8'h83, 8'h00, 8'h00};
        aw = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) txn(0, aw[i], aa[i], ad[i], as, ak);
      end
      begin
        int bs, bk;
        txn(1, 0, 13'h0012, 8'h00, bs, bk);
        chk("t4_wait_cnt", 32'(dut.wait_cnt), 0);
        chk("t4_b_latency", 32'(bk - bs), 19);
      end
    join

    // T5: B alone writes
    expect_txn(1, 1, 13'h0400, 8'hA5);
    txn(1, 1, 13'h0400, 8'hA5, s0, k0);
    @(negedge clk_sys);
    chk("t5_mem", 32'(mem[13'h0400]), 32'hA5);

    // T6: reset during CYC of an A write; request re-served after release
    preload(13'h0055, 8'h11);
    sh_last[0] = '0;
    sh_last[1] = '0;
    expect_txn(0, 1, 13'h0055, 8'h77);
    fork
      txn(0, 1, 13'h0055, 8'h77, s0, k0);
      begin
        repeat (2) @(negedge clk_sys);
        chk("t6_cyc_we", 32'(ram_we), 1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_we", 32'(ram_we), 0);
        chk("t6_rst_addr", 32'(ram_addr), 0);
        chk("t6_rst_wdata", 32'(ram_wdata), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_owner", 32'(owner), 0);
        chk("t6_rst_a_ack", 32'(a_ack), 0);
        chk("t6_rst_a_rdata", 32'(a_rdata), 0);
        chk("t6_rst_b_rdata", 32'(b_rdata), 0);
        @(negedge clk_sys);
        chk("t6_mem_kept", 32'(mem[13'h0055]), 32'h11);
        #2 reset = 1'b0;
      end
    join
    chk("t6_latency", 32'(k0 - s0), 5);
    @(negedge clk_sys);
    chk("t6_mem", 32'(mem[13'h0055]), 32'h77);

    repeat (8) @(negedge clk_sys);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
